alu_arbiter: RTL and testbench

- Shares one `alu_nzcv` instance between two requesters (r0, r1) using round-robin arbitration with valid/ready handshakes.
- Registers the ALU result, NZCV flags and requester ID into a one-entry response buffer.
- Keeps an architectural NZCV flags register, updated only by operations that request it.
- Sits between the two issue ports of the datapath and the shared ALU.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_nzcv.sv | 40 ++++
 rtl/rr_arb2.sv | 33 +++
 rtl/alu_arbiter.sv | 162 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU and arbiter types: ALU opcodes, NZCV bit positions and response-buffer states.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  localparam int unsigned NZCV_N = 3;
  localparam int unsigned NZCV_Z = 2;
  localparam int unsigned NZCV_C = 1;
  localparam int unsigned NZCV_V = 0;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_t;

endpackage

// File: rtl/alu_nzcv.sv
// Combinational N-bit ALU (add/sub/and/or) producing ARM-style NZCV flags.
module alu_nzcv
  import alu_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [1:0]   i_ctrl,
  output logic [N-1:0] o_result,
  output logic [3:0]   o_nzcv
);

  alu_op_t      w_op;
  logic [N-1:0] w_b_op;
  logic [N:0]   w_sum;

  assign w_op = alu_op_t'(i_ctrl);

  // Subtract is a + ~b + 1, so C means "no borrow"
  always_comb begin
    o_result = '0;
    o_nzcv   = 4'b0000;
    w_b_op   = (w_op == ALU_SUB) ? ~i_b : i_b;
    w_sum    = {1'b0, i_a} + {1'b0, w_b_op} + {{N{1'b0}}, (w_op == ALU_SUB)};
    case (w_op)
      ALU_ADD, ALU_SUB: begin
        o_result       = w_sum[N-1:0];
        o_nzcv[NZCV_C] = w_sum[N];
        o_nzcv[NZCV_V] = (i_a[N-1] == w_b_op[N-1]) && (w_sum[N-1] != i_a[N-1]);
      end
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      default: o_result = '0;
    endcase
    o_nzcv[NZCV_N] = o_result[N-1];
    o_nzcv[NZCV_Z] = (o_result == '0);
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; ready for one requester never looks at its own valid.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_ready,
  output logic [1:0] o_gnt
);

  logic r_ptr;

  // A requester is ready if the other is idle or the pointer favours it
  always_comb begin
    o_ready[0] = i_en & (~i_req[1] | ~r_ptr);
    o_ready[1] = i_en & (~i_req[0] |  r_ptr);
    o_gnt      = o_ready & i_req;
  end

  // Pointer moves to the other requester after every grant
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= 1'b0;
    end else if (o_gnt[0]) begin
      r_ptr <= 1'b1;
    end else if (o_gnt[1]) begin
      r_ptr <= 1'b0;
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one alu_nzcv between two requesters with a one-entry response buffer.
// Optional stall counters are enabled with the macro ALU_ARB_STALL_CNT_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N = 64
`ifdef ALU_ARB_STALL_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [1:0]   i_req_valid,
  output logic [1:0]   o_req_ready,
  input  logic [N-1:0] i_a0,
  input  logic [N-1:0] i_b0,
  input  logic [1:0]   i_ctrl0,
  input  logic         i_setf0,
  input  logic [N-1:0] i_a1,
  input  logic [N-1:0] i_b1,
  input  logic [1:0]   i_ctrl1,
  input  logic         i_setf1,
  output logic         o_rsp_valid,
  input  logic         i_rsp_ready,
  output logic         o_rsp_id,
  output logic [N-1:0] o_result,
  output logic [3:0]   o_nzcv,
  output logic [3:0]   o_flags
`ifdef ALU_ARB_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] o_stall_cnt0,
  output logic [CNT_W-1:0] o_stall_cnt1
`endif
);

  rsp_state_t   r_state;
  rsp_state_t   w_state_nxt;
  logic         w_can_load;
  logic [1:0]   w_gnt;
  logic         w_fire;
  logic         w_sel1;
  logic [N-1:0] w_alu_a;
  logic [N-1:0] w_alu_b;
  logic [1:0]   w_alu_ctrl;
  logic         w_setf;
  logic [N-1:0] w_alu_res;
  logic [3:0]   w_alu_nzcv;
  logic [N-1:0] r_result;
  logic [3:0]   r_nzcv;
  logic         r_id;
  logic [3:0]   r_flags;

  assign w_can_load = (r_state == RSP_EMPTY) | i_rsp_ready;
  assign w_fire     = |w_gnt;
  assign w_sel1     = w_gnt[1];

  rr_arb2 u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   (i_req_valid),
    .i_en    (w_can_load),
    .o_ready (o_req_ready),
    .o_gnt   (w_gnt)
  );

  assign w_alu_a    = w_sel1 ? i_a1    : i_a0;
  assign w_alu_b    = w_sel1 ? i_b1    : i_b0;
  assign w_alu_ctrl = w_sel1 ? i_ctrl1 : i_ctrl0;
  assign w_setf     = w_sel1 ? i_setf1 : i_setf0;

  alu_nzcv #(.N(N)) u_alu (
    .i_a      (w_alu_a),
    .i_b      (w_alu_b),
    .i_ctrl   (w_alu_ctrl),
    .o_result (w_alu_res),
    .o_nzcv   (w_alu_nzcv)
  );

  // Response buffer state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RSP_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A load wins over a drain, so drain+load in one cycle stays FULL
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RSP_EMPTY: w_state_nxt = w_fire ? RSP_FULL : RSP_EMPTY;
      RSP_FULL: begin
        if (w_fire) begin
          w_state_nxt = RSP_FULL;
        end else if (i_rsp_ready) begin
          w_state_nxt = RSP_EMPTY;
        end else begin
          w_state_nxt = RSP_FULL;
        end
      end
      default: w_state_nxt = RSP_EMPTY;
    endcase
  end

  // Buffered payload and architectural flags; drained entries keep stale data
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_result <= '0;
      r_nzcv   <= 4'b0000;
      r_id     <= 1'b0;
      r_flags  <= 4'b0000;
    end else if (w_fire) begin
      r_result <= w_alu_res;
      r_nzcv   <= w_alu_nzcv;
      r_id     <= w_sel1;
      r_flags  <= w_setf ? w_alu_nzcv : r_flags;
    end else begin
      r_result <= r_result;
      r_nzcv   <= r_nzcv;
      r_id     <= r_id;
      r_flags  <= r_flags;
    end
  end

  assign o_rsp_valid = (r_state == RSP_FULL);
  assign o_rsp_id    = r_id;
  assign o_result    = r_result;
  assign o_nzcv      = r_nzcv;
  assign o_flags     = r_flags;

`ifdef ALU_ARB_STALL_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_stall0;
  logic [CNT_W-1:0] r_stall1;

  // Saturating counts of cycles each requester waited
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall0 <= '0;
      r_stall1 <= '0;
    end else begin
      if (i_req_valid[0] && !o_req_ready[0] && !(&r_stall0)) begin
        r_stall0 <= r_stall0 + CNT_ONE;
      end else begin
        r_stall0 <= r_stall0;
      end
      if (i_req_valid[1] && !o_req_ready[1] && !(&r_stall1)) begin
        r_stall1 <= r_stall1 + CNT_ONE;
      end else begin
        r_stall1 <= r_stall1;
      end
    end
  end

  assign o_stall_cnt0 = r_stall0;
  assign o_stall_cnt1 = r_stall1;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter (N=8): directed steps followed by random traffic
// compared against a behavioural model of the arbiter, buffer and flags.
module tb_alu_arbiter;

  localparam int N = 8;
  localparam int CMAX = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] a0, b0, a1, b1;
  logic [1:0] ctrl0, ctrl1;
  logic       setf0, setf1;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] result;
  logic [3:0] nzcv, flags;
`ifdef ALU_ARB_STALL_CNT_EN
  logic [1:0] stall0, stall1;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state
  bit         m_valid;
  int         m_id;
  logic [7:0] m_res;
  logic [3:0] m_nzcv;
  logic [3:0] m_flags;
  int         m_prio;
  int         m_cnt0, m_cnt1;
  int         last_g;

  always #5 clk = ~clk;

  alu_arbiter #(
    .N(N)
`ifdef ALU_ARB_STALL_CNT_EN
    , .CNT_W(2)
`endif
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_a0        (a0),
    .i_b0        (b0),
    .i_ctrl0     (ctrl0),
    .i_setf0     (setf0),
    .i_a1        (a1),
    .i_b1        (b1),
    .i_ctrl1     (ctrl1),
    .i_setf1     (setf1),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_id    (rsp_id),
    .o_result    (result),
    .o_nzcv      (nzcv),
    .o_flags     (flags)
`ifdef ALU_ARB_STALL_CNT_EN
    , .o_stall_cnt0 (stall0),
    .o_stall_cnt1 (stall1)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: signed overflow from integer range, carry from unsigned range
  task automatic ref_alu(input int op, input int a, input int b,
                         output logic [7:0] res, output logic [3:0] f);
    int r, sa, sb, sr;
    bit c, v;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    c = 1'b0;
    v = 1'b0;
    case (op)
      0: begin r = a + b; c = (r > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
      1: begin r = a - b; c = (a >= b);  sr = sa - sb; v = (sr > 127) || (sr < -128); end
      2: r = a & b;
      default: r = a | b;
    endcase
    res = 8'(r & 255);
    f = {res[7], (res == 8'h00), c, v};
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_id = 0; m_res = 8'h00; m_nzcv = 4'h0; m_flags = 4'h0;
    m_prio = 0; m_cnt0 = 0; m_cnt1 = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, m_valid);
    chk({tag, "_rsp_id"}, rsp_id, m_id);
    chk({tag, "_result"}, result, m_res);
    chk({tag, "_nzcv"}, nzcv, m_nzcv);
    chk({tag, "_flags"}, flags, m_flags);
`ifdef ALU_ARB_STALL_CNT_EN
    chk({tag, "_stall0"}, stall0, m_cnt0);
    chk({tag, "_stall1"}, stall1, m_cnt1);
`endif
  endtask

  // One clock: check combinational ready mid-cycle, advance model, check registers after edge
  task automatic do_cycle(input string tag);
    bit can_load, er0, er1;
    logic [7:0] res;
    logic [3:0] f;
    #3;
    can_load = !m_valid || rsp_ready;
    er0 = can_load && (!req_valid[1] || m_prio == 0);
    er1 = can_load && (!req_valid[0] || m_prio == 1);
    chk({tag, "_req_ready"}, req_ready, {er1, er0});
    last_g = -1;
    if (req_valid[0] && er0) last_g = 0;
    else if (req_valid[1] && er1) last_g = 1;
    if (req_valid[0] && !er0 && m_cnt0 < CMAX) m_cnt0++;
    if (req_valid[1] && !er1 && m_cnt1 < CMAX) m_cnt1++;
    if (last_g == 0) begin
      ref_alu(ctrl0, a0, b0, res, f);
      m_valid = 1'b1; m_id = 0; m_res = res; m_nzcv = f; m_prio = 1;
      if (setf0) m_flags = f;
    end else if (last_g == 1) begin
      ref_alu(ctrl1, a1, b1, res, f);
      m_valid = 1'b1; m_id = 1; m_res = res; m_nzcv = f; m_prio = 0;
      if (setf1) m_flags = f;
    end else if (m_valid && rsp_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
    a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
    ctrl0 = 2'b00; ctrl1 = 2'b00; setf0 = 1'b0; setf1 = 1'b0;
    model_reset();
    #12;
    check_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single subtract from r0
    req_valid = 2'b01; a0 = 8'h05; b0 = 8'h03; ctrl0 = 2'b01; setf0 = 1'b1; rsp_ready = 1'b1;
    do_cycle("single");
    chk("single_grant", last_g, 0);
    chk("single_result_k", result, 8'h02);
    chk("single_nzcv_k", nzcv, 4'b0010);
    chk("single_flags_k", flags, 4'b0010);

    // Signed overflow from r1
    req_valid = 2'b10; a1 = 8'h7F; b1 = 8'h01; ctrl1 = 2'b00; setf1 = 1'b1;
    do_cycle("ovf");
    chk("ovf_nzcv_k", nzcv, 4'b1001);
    chk("ovf_flags_k", flags, 4'b1001);

    // Contention with pointer at r0; r0 does an AND without setting flags
    req_valid = 2'b11;
    a0 = 8'hF0; b0 = 8'h3C; ctrl0 = 2'b10; setf0 = 1'b0;
    a1 = 8'h10; b1 = 8'h20; ctrl1 = 2'b01; setf1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_cycle("contend");
      chk("contend_id_k", rsp_id, (i == 1) ? 1 : 0);
      chk("contend_flags_k", flags, 4'b1001);
    end
    chk("contend_and_k", result, 8'h30);

    // Backpressure with r1 waiting
    req_valid = 2'b10; rsp_ready = 1'b0; a1 = 8'h44; b1 = 8'h22; ctrl1 = 2'b11; setf1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_cycle("bp");
      chk("bp_ready1_k", req_ready[1], 1'b0);
    end
    rsp_ready = 1'b1;
    do_cycle("bp_release");
    chk("bp_release_grant", last_g, 1);
    chk("bp_release_result_k", result, 8'h66);

    // Asynchronous reset while FULL
    req_valid = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_rsp_valid", rsp_valid, 1'b0);
    chk("arst_flags", flags, 4'b0000);
    chk("arst_result", result, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid = 2'b11;
    do_cycle("post_rst");
    chk("post_rst_grant", last_g, 0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      req_valid = 2'($urandom_range(0, 3));
      a0 = 8'($urandom); b0 = 8'($urandom); ctrl0 = 2'($urandom); setf0 = 1'($urandom);
      a1 = 8'($urandom); b1 = 8'($urandom); ctrl1 = 2'($urandom); setf1 = 1'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      do_cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
